// File: rtl/mips_regfile_pkg.sv
// Shared constants for the MIPS register file and the
// destination-select stage.
package mips_regfile_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA = 5'd31;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: busy bits, set/clear priority,
// write-back-aware hazard lookups and busy popcount.
module reg_scoreboard
  import mips_regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_REGS = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_dest,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_dest,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [ADDR_WIDTH-1:0] addr_c,
  output logic                  eff_a,
  output logic                  eff_b,
  output logic                  eff_c,
  output logic [ADDR_WIDTH:0]   busy_count
);
  localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;

  // A register being written back this cycle no longer blocks.
  always_comb begin
    eff_a = busy_q[addr_a] && !(wb_en && wb_dest == addr_a);
    eff_b = busy_q[addr_b] && !(wb_en && wb_dest == addr_b);
    eff_c = busy_q[addr_c] && !(wb_en && wb_dest == addr_c);
  end

  // Set is applied after clear so a same-cycle reissue stays busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_en) busy_d[wb_dest] = 1'b0;
    if (set_en && set_dest != ZERO) busy_d[set_dest] = 1'b1;
    busy_d[0] = 1'b0;
    if (rst) busy_d = '0;
    cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++)
      cnt_d = cnt_d + (ADDR_WIDTH+1)'(busy_d[i]);
  end

  always_ff @(posedge clk) begin
    busy_q <= busy_d;
    cnt_q  <= cnt_d;
  end

  assign busy_count = cnt_q;
endmodule

// File: rtl/reg_bank_wb.sv
// Register bank with write-back bypass and a pending-write
// scoreboard that stalls decode on RAW/WAW hazards.
module reg_bank_wb
  import mips_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_REGS = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  output logic [DATA_WIDTH-1:0] rs_data,
  output logic [DATA_WIDTH-1:0] rt_data,
  input  logic                  issue_valid,
  input  logic                  issue_wr,
  input  logic [ADDR_WIDTH-1:0] issue_dest,
  output logic                  stall,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_dest,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [ADDR_WIDTH:0]   busy_count
);
  localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic eff_rs, eff_rt, eff_dst;
  logic set_en;

  always_comb begin
    regs_d = regs_q;
    if (wb_en && wb_dest != ZERO) regs_d[wb_dest] = wb_data;
    if (rst)
      for (int i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs_addr != ZERO)
      rs_data = (wb_en && wb_dest == rs_addr) ? wb_data : regs_q[rs_addr];
    if (rt_addr != ZERO)
      rt_data = (wb_en && wb_dest == rt_addr) ? wb_data : regs_q[rt_addr];
  end

  always_comb begin
    stall  = issue_valid && (eff_rs || eff_rt || (issue_wr && eff_dst));
    set_en = issue_valid && !stall && issue_wr;
  end

  reg_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_REGS  (NUM_REGS)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .wb_en     (wb_en),
    .wb_dest   (wb_dest),
    .set_en    (set_en),
    .set_dest  (issue_dest),
    .addr_a    (rs_addr),
    .addr_b    (rt_addr),
    .addr_c    (issue_dest),
    .eff_a     (eff_rs),
    .eff_b     (eff_rt),
    .eff_c     (eff_dst),
    .busy_count(busy_count)
  );
endmodule
